// File: rtl/serial_add_sub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package serial_add_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SLICE = 4;

endpackage

// File: rtl/serial_add_sub_ctrl_nibble_slice.sv
// SLICE-bit ripple adder shared across every step of a serial operation.
// Combinational, zero latency, no flow control.
module nibble_slice #(
  parameter int SLICE = serial_add_sub_ctrl_pkg::DEFAULT_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  end

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Nibble-serial add/sub: one shared SLICE-bit adder walked over WIDTH/SLICE steps.
// Result valid WIDTH/SLICE cycles after accept; holds in DONE while out_ready is low.
module serial_add_sub_ctrl
  import serial_add_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STEPS = WIDTH / SLICE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(STEPS - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, carry_out_q, overflow_q;
  logic             in_ready_q, out_valid_q;
  logic [CW-1:0]    idx_q;

  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;

  assign slice_a = a_q[idx_q*SLICE +: SLICE];
  assign slice_b = b_q[idx_q*SLICE +: SLICE];

  nibble_slice #(.SLICE(SLICE)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            // Subtract is a + ~b + 1: invert b once here, seed carry with mode.
            a_q        <= a;
            b_q        <= b ^ {WIDTH{mode}};
            carry_q    <= mode;
            idx_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*SLICE +: SLICE] <= slice_sum;
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            carry_out_q <= slice_cout;
            overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (slice_sum[SLICE-1] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Directed bench for serial_add_sub_ctrl with hand-computed expected results.
module tb_serial_add_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  serial_add_sub_ctrl #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation for one edge; caller is left 1ns after the accept edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic m);
    a = av; b = bv; mode = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic [15:0] av, input logic [15:0] bv,
                               input logic m, input logic [15:0] es, input logic ec, input logic eo);
    int cyc;
    start_op(av, bv, m);
    wait_out(cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL %s latency: got %0d want 4", name, cyc); end
    checks++;
    if ({sum, carry_out, overflow} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL %s result: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
               name, sum, carry_out, overflow, es, ec, eo);
    end
    release_out();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, sum, carry_out, overflow} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b sum=%h c=%b v=%b want rdy=1 vld=0 sum=0 c=0 v=0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add in_ready: got %b want 1", in_ready); end
    run_and_check("add", 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL add return_idle: got vld/rdy=%b%b want 01", out_valid, in_ready);
    end
  endtask

  task automatic test_add_wrap();
    run_and_check("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_sub_borrow();
    run_and_check("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    run_and_check("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_and_check("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad = 0;
    start_op(16'h0100, 16'h0023, 1'b0);
    wait_out(cyc);
    for (int i = 0; i < 10; i++) begin
      a = 16'(i * 16'h1111); b = ~a; mode = i[0]; in_valid = 1'b1;
      tick();
      if ({out_valid, in_ready, sum, carry_out, overflow} !== {1'b1, 1'b0, 16'h0123, 1'b0, 1'b0})
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure hold: got %0d bad cycles (last vld=%b rdy=%b sum=%h) want 0",
               bad, out_valid, in_ready, sum);
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL backpressure release: got vld/rdy=%b%b want 01", out_valid, in_ready);
    end
    run_and_check("after_bp", 16'h4000, 16'h1000, 1'b1, 16'h3000, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    start_op(16'hAAAA, 16'h5555, 1'b0);
    tick(); tick();
    checks++;
    if ({sum, out_valid} !== {16'h00FF, 1'b0}) begin
      errors++; $display("FAIL partial_sum: got sum=%h vld=%b want sum=00ff vld=0", sum, out_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({out_valid, sum, in_ready, carry_out, overflow} !== {1'b0, 16'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_run_reset: got vld=%b sum=%h rdy=%b c=%b v=%b want vld=0 sum=0 rdy=1 c=0 v=0",
               out_valid, sum, in_ready, carry_out, overflow);
    end
    rst_n = 1'b1;
    tick();
    run_and_check("post_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int gap;
    start_op(16'h0F0F, 16'h00F1, 1'b0);
    wait_out(cyc);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    a = 16'h0010; b = 16'h0011; mode = 1'b1; in_valid = 1'b1;
    gap = 0;
    while (!in_ready && gap < 10) begin tick(); gap++; end
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    checks++;
    if ({gap, sum, carry_out, overflow} !== {32'd0, 16'hFFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back: got gap=%0d sum=%h c=%b v=%b want gap=0 sum=ffff c=0 v=0",
               gap, sum, carry_out, overflow);
    end
    release_out();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_add_wrap();
    test_sub_borrow();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
